cube_face_viewer: RTL and testbench
===================================

# cube_face_viewer

Downstream consumer of the cube move engine's 162-bit flattened cube state: snapshots the cube, runs a sequential solved check, and presents one face at a time on the DE-series seven-segment displays and LEDs. It supplies the `solved` flag the top-level FSM uses for its VERIFY→DONE transition. It also gives the operator a stepping view of the facelets of the face selected on the switches.

## Interface

Parameters:
- DWELL, 25_000_000 — clk cycles each facelet is shown before the pointer advances (0.5 s at 50 MHz); minimum 2.

Ports:
- Clocking: reset rst_n, asynchronous, active-low; clock clk.
- cube_flat  in  162  cube state; sticker i (0..53) = bits [3i+2:3i]; face f owns stickers 9f..9f+8; centre = 9f+4.
- cube_valid  in  1  single-cycle strobe: cube_flat is new; snapshot and check.
- face_sel  in  3  face to display; 0..5 valid, 6/7 invalid.
- hold  in  1  freezes the facelet pointer and dwell counter.
- hex0..hex3  out  7 each  segments, active-low, bit 0 = seg a.
- ledr  out  10  [8:0] facelet-matches-centre map, [9] = solved.
- solved  out  1  result of last completed check; held until the next completed check.
- solved_valid  out  1  single-cycle pulse when `solved` updates.

## Operation

- Snapshot: `cube_valid` loads `cube_flat` into shadow register `snap`. All display and check logic reads `snap`, never `cube_flat` directly.
- Checker FSM:
  - States are IDLE, SCAN and REPORT.
  - IDLE→SCAN on `cube_valid`; `idx`←0; `mismatch`←0.
  - In SCAN, each cycle compares `snap` sticker `idx` against the centre of face `idx/9`. Any inequality sets `mismatch`. `idx` increments; after `idx`=53, go to REPORT.
  - In REPORT, `solved`←~`mismatch`, `solved_valid`=1, →IDLE.
- `cube_valid` in SCAN or REPORT:
  - Re-snapshots and restarts the scan at `idx`=0.
  - An aborted scan produces no `solved_valid`, and `solved` keeps its old value.
- Viewer pointer:
  - `ptr` counts 0..8 and `dcnt` counts 0..DWELL-1.
  - When `dcnt`=DWELL-1, `dcnt`←0 and `ptr`←`ptr`+1, wrapping 8→0.
  - `hold`=1 freezes both counters.
  - Any change of `face_sel` from its registered previous value forces `ptr`←0 and `dcnt`←0. This takes priority over `hold`.
- Display for valid `face_sel`:
  - hex3 = digit of `face_sel`; hex2 = blank (7'h7F); hex1 = digit of `ptr`; hex0 = colour code of sticker 9·`face_sel`+`ptr`.
  - Colour codes 0..5 show as digits. Codes 6/7 show as a dash (7'b0111111).
  - ledr[k] = (sticker 9·`face_sel`+k == centre of `face_sel`) for k = 0..8.
- Display for invalid `face_sel` (6/7): hex3..hex0 all dashes, ledr[8:0]=0.
- ledr[9] = `solved` in all cases.
- Reset values:
  - `snap`=0; FSM=IDLE; `idx`/`ptr`/`dcnt`=0.
  - hex0..hex3 = 7'h7F; ledr=0; `solved`=0; `solved_valid`=0.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Check latency:
  - `cube_valid` is sampled at edge E; `snap` loads at E.
  - SCAN covers idx 0..53 at edges E+1..E+54.
  - REPORT is entered at E+55, so `solved`/`solved_valid` are visible after E+56.
  - The latency is fixed at 56 cycles regardless of where a mismatch occurs.
- Display latency:
  - hex/ledr reflect `snap`, `face_sel` and `ptr` one cycle after they change.
  - After a new snapshot, the display updates one cycle later, independent of the checker.
- Reset asserted mid-scan: immediate return to reset values; no `solved_valid` is emitted.
- Simultaneous `cube_valid` and REPORT: the restart wins and `solved_valid` stays 0.
- `dcnt` is sized to `$clog2(DWELL)`; `idx` is 6 bits and `ptr` is 4 bits.

## Structure

- The shared `cube_pkg` holds:
  - Constants: FACES=6, FACELETS=9, COLOR_W=3, CUBE_W=162, CENTRE=4.
  - Function `sticker(flat, i)`.
  - Colour code enum, matching the move engine's face-colour encoding (face f solved colour = f).
- One natural sub-module is `seg7_digit`: a combinational 4-bit→7-segment active-low encoder with a dash/blank select, instantiated four times.
- Everything else lives in a single `cube_face_viewer` module, with the FSM, pointer and display registers as separate always blocks.

## Test plan

1. Solved cube (sticker i = i/9) with a `cube_valid` pulse → `solved_valid` pulses exactly 56 cycles later, `solved`=1, ledr = 10'h3FF for `face_sel`=2.
2. Sticker 53 set to 0, then `cube_valid` → `solved`=0 at the same 56-cycle latency; with `face_sel`=5 and `ptr`=8: ledr[8]=0, hex0 shows "0".
3. With DWELL=4, `face_sel`=1, `hold`=0 → hex1 steps 0..8 every 4 cycles, wrapping 8→0. Raising `hold` freezes hex1; changing `face_sel` to 3 while held → hex1=0 on the next cycle.
4. Second `cube_valid` 20 cycles into a scan → no `solved_valid` at the original deadline; one pulse 56 cycles after the second strobe.
5. `face_sel`=7 → all hex show dashes (7'b0111111), ledr[8:0]=0, ledr[9] tracks `solved`.
6. `rst_n` low at scan cycle 30 → hex = 7'h7F, ledr=0, `solved`=0, and no `solved_valid` pulse after release.

Source files
------------

// File: rtl/cube_pkg.sv
// cube_pkg: shared constants, colour encoding and sticker accessor for the
// flattened 162-bit cube state (sticker i = bits [3i+2:3i]).
package cube_pkg;

  localparam int FACES    = 6;
  localparam int FACELETS = 9;
  localparam int COLOR_W  = 3;
  localparam int CUBE_W   = 162;
  localparam int CENTRE   = 4;

  // Solved colour of face f is code f, same as the move engine.
  typedef enum logic [COLOR_W-1:0] {
    COL_U = 3'd0, COL_R = 3'd1, COL_F = 3'd2,
    COL_D = 3'd3, COL_L = 3'd4, COL_B = 3'd5
  } colour_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } chk_state_e;

  // Caller keeps i within 0..53.
  function automatic logic [COLOR_W-1:0] sticker(input logic [CUBE_W-1:0] flat,
                                                 input logic [5:0] i);
    return flat[COLOR_W*i +: COLOR_W];
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: combinational 4-bit value to active-low seven-segment pattern
// (bit 0 = seg a). i_dash shows only segment g and overrides i_blank.
//   i_val   value 0..F
//   i_dash  force a dash
//   i_blank force all segments off
//   o_seg   segment pattern
module seg7_digit (
  input  logic [3:0] i_val,
  input  logic       i_dash,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    if (i_dash) begin
      o_seg = 7'h3F;
    end else if (!i_blank) begin
      case (i_val)
        4'h0: o_seg = 7'h40;
        4'h1: o_seg = 7'h79;
        4'h2: o_seg = 7'h24;
        4'h3: o_seg = 7'h30;
        4'h4: o_seg = 7'h19;
        4'h5: o_seg = 7'h12;
        4'h6: o_seg = 7'h02;
        4'h7: o_seg = 7'h78;
        4'h8: o_seg = 7'h00;
        4'h9: o_seg = 7'h10;
        4'hA: o_seg = 7'h08;
        4'hB: o_seg = 7'h03;
        4'hC: o_seg = 7'h46;
        4'hD: o_seg = 7'h21;
        4'hE: o_seg = 7'h06;
        default: o_seg = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/cube_face_viewer.sv
// cube_face_viewer: snapshots the cube state, runs a 56-cycle sequential
// solved check, and steps through the facelets of the selected face on the
// seven-segment displays and LEDs.
//   clk, rst_n    clock, async active-low reset
//   cube_flat     162-bit cube state
//   cube_valid    strobe: snapshot cube_flat and (re)start the check
//   face_sel      face to show (6/7 invalid -> dashes)
//   hold          freeze facelet pointer and dwell counter
//   hex0..hex3    active-low segments (hex3 face, hex2 blank, hex1 ptr, hex0 colour)
//   ledr          [8:0] facelet==centre map, [9] solved
//   solved        result of last completed check
//   solved_valid  one-cycle pulse when solved updates
module cube_face_viewer
  import cube_pkg::*;
#(
  parameter int DWELL = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CUBE_W-1:0] cube_flat,
  input  logic              cube_valid,
  input  logic [2:0]        face_sel,
  input  logic              hold,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [9:0]        ledr,
  output logic              solved,
  output logic              solved_valid
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CUBE_W-1:0] r_snap;
  chk_state_e        r_state;
  logic [5:0]        r_idx;
  logic              r_mismatch, r_solved, r_solved_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_snap <= '0;
    else if (cube_valid) r_snap <= cube_flat;
  end

  // ---------------- checker ----------------
  logic [5:0]         w_sidx, w_cidx;
  logic [COLOR_W-1:0] w_cur, w_ctr;

  assign w_sidx = (r_idx < 6'd54) ? r_idx : 6'd0;
  assign w_cidx = (w_sidx / 6'(FACELETS)) * 6'(FACELETS) + 6'(CENTRE);
  assign w_cur  = sticker(r_snap, w_sidx);
  assign w_ctr  = sticker(r_snap, w_cidx);

  // idx=54 is a sentinel cycle after the last compare; it fixes the
  // strobe-to-result latency at 56 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_mismatch     <= 1'b0;
      r_solved       <= 1'b0;
      r_solved_valid <= 1'b0;
    end else begin
      r_solved_valid <= 1'b0;
      if (cube_valid) begin
        // a new strobe always restarts, even over REPORT
        r_state    <= ST_SCAN;
        r_idx      <= '0;
        r_mismatch <= 1'b0;
      end else begin
        case (r_state)
          ST_SCAN: begin
            if (r_idx == 6'd54) begin
              r_state <= ST_REPORT;
            end else begin
              if (w_cur != w_ctr) r_mismatch <= 1'b1;
              r_idx <= r_idx + 6'd1;
            end
          end
          ST_REPORT: begin
            r_solved       <= ~r_mismatch;
            r_solved_valid <= 1'b1;
            r_state        <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- facelet pointer ----------------
  logic [2:0]     r_face_prev;
  logic [3:0]     r_ptr, w_ptr_nxt;
  logic [DCW-1:0] r_dcnt, w_dcnt_nxt;

  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_dcnt_nxt = r_dcnt;
    if (face_sel != r_face_prev) begin
      w_ptr_nxt  = '0;
      w_dcnt_nxt = '0;
    end else if (!hold) begin
      if (r_dcnt == DCW'(DWELL - 1)) begin
        w_dcnt_nxt = '0;
        w_ptr_nxt  = (r_ptr == 4'd8) ? 4'd0 : r_ptr + 4'd1;
      end else begin
        w_dcnt_nxt = r_dcnt + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_dcnt      <= '0;
      r_face_prev <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_face_prev <= face_sel;
    end
  end

  // ---------------- display ----------------
  // Built from the pointer's next value so hex1 moves on the same edge as ptr.
  logic               w_valid, w_bad_col;
  logic [5:0]         w_base;
  logic [COLOR_W-1:0] w_col, w_ctr_f;
  logic [8:0]         w_led;
  logic [6:0]         w_hex0, w_hex1, w_hex2, w_hex3;

  assign w_valid   = face_sel < 3'(FACES);
  assign w_base    = w_valid ? {3'b000, face_sel} * 6'(FACELETS) : 6'd0;
  assign w_col     = sticker(r_snap, w_base + {2'b00, w_ptr_nxt});
  assign w_ctr_f   = sticker(r_snap, w_base + 6'(CENTRE));
  assign w_bad_col = w_col > COL_B;

  always_comb begin
    w_led = '0;
    for (int k = 0; k < FACELETS; k++)
      w_led[k] = w_valid && (sticker(r_snap, w_base + 6'(k)) == w_ctr_f);
  end

  seg7_digit u_hex3 (.i_val({1'b0, face_sel}), .i_dash(!w_valid), .i_blank(1'b0),
                     .o_seg(w_hex3));
  seg7_digit u_hex2 (.i_val(4'd0), .i_dash(!w_valid), .i_blank(w_valid),
                     .o_seg(w_hex2));
  seg7_digit u_hex1 (.i_val(w_ptr_nxt), .i_dash(!w_valid), .i_blank(1'b0),
                     .o_seg(w_hex1));
  seg7_digit u_hex0 (.i_val({1'b0, w_col}), .i_dash(!w_valid || w_bad_col), .i_blank(1'b0),
                     .o_seg(w_hex0));

  logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3;
  logic [8:0] r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex0 <= 7'h7F;
      r_hex1 <= 7'h7F;
      r_hex2 <= 7'h7F;
      r_hex3 <= 7'h7F;
      r_led  <= '0;
    end else begin
      r_hex0 <= w_hex0;
      r_hex1 <= w_hex1;
      r_hex2 <= w_hex2;
      r_hex3 <= w_hex3;
      r_led  <= w_led;
    end
  end

  assign hex0         = r_hex0;
  assign hex1         = r_hex1;
  assign hex2         = r_hex2;
  assign hex3         = r_hex3;
  assign ledr         = {r_solved, r_led};
  assign solved       = r_solved;
  assign solved_valid = r_solved_valid;

endmodule

// File: tb/tb_cube_face_viewer.sv
module tb_cube_face_viewer;

  logic         clk, rst_n, cube_valid, hold;
  logic [161:0] cube_flat;
  logic [2:0]   face_sel;
  logic [6:0]   hex0, hex1, hex2, hex3;
  logic [9:0]   ledr;
  logic         solved, solved_valid;

  int n_vec = 0;
  int n_err = 0;

  // active-low digit patterns 0..9, bit 0 = seg a
  logic [6:0] DIG [0:9];
  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] BLANK = 7'h7F;

  cube_face_viewer #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .cube_flat(cube_flat), .cube_valid(cube_valid),
    .face_sel(face_sel), .hold(hold), .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .ledr(ledr), .solved(solved), .solved_valid(solved_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [161:0] solved_cube();
    logic [161:0] c;
    c = '0;
    for (int i = 0; i < 54; i++) c[3*i +: 3] = 3'(i / 9);
    return c;
  endfunction

  function automatic logic [161:0] unsolved_cube();
    logic [161:0] c;
    c = solved_cube();
    c[161:159] = 3'd0;  // sticker 53 -> colour 0
    return c;
  endfunction

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe cube_valid for one edge (edge E); returns at E+1ns.
  task automatic pulse(input logic [161:0] c);
    @(negedge clk);
    cube_flat  = c;
    cube_valid = 1'b1;
    @(posedge clk);
    #1 cube_valid = 1'b0;
  endtask

  // Watch n cycles after a strobe; report count of pulses and first offset.
  task automatic watch(input int n, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (solved_valid) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cube_valid = 1'b0; hold = 1'b0; face_sel = 3'd0; cube_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk7("rst_hex0", hex0, BLANK);
    chk7("rst_hex1", hex1, BLANK);
    chk7("rst_hex2", hex2, BLANK);
    chk7("rst_hex3", hex3, BLANK);
    chk10("rst_ledr", ledr, 10'h000);
    chk7("rst_solved", {6'd0, solved}, 7'd0);
    chk7("rst_sv", {6'd0, solved_valid}, 7'd0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_solved();
    int cnt, first;
    @(negedge clk) face_sel = 3'd2;
    pulse(solved_cube());
    watch(56, cnt, first);
    chk7("solved_pulse_cnt", 7'(cnt), 7'd1);
    chk7("solved_latency", 7'(first), 7'd56);
    chk7("solved_flag", {6'd0, solved}, 7'd1);
    chk10("solved_ledr", ledr, 10'h3FF);
    chk7("solved_hex3", hex3, DIG[2]);
    chk7("solved_hex2", hex2, BLANK);
  endtask

  task automatic test_unsolved();
    int cnt, first;
    bit found;
    @(negedge clk) face_sel = 3'd5;
    pulse(unsolved_cube());
    watch(56, cnt, first);
    chk7("unsolved_latency", 7'(first), 7'd56);
    chk7("unsolved_flag", {6'd0, solved}, 7'd0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (hex1 === DIG[8]) found = 1'b1;
    end
    hold = 1'b1;
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL ptr8_search: hex1 never showed 8 within 60 cycles");
    end
    @(posedge clk); #1;
    chk7("unsolved_hex1_held8", hex1, DIG[8]);
    chk7("unsolved_hex0", hex0, DIG[0]);
    chk10("unsolved_ledr", ledr, 10'h0FF);
  endtask

  task automatic test_pointer();
    @(negedge clk);
    face_sel = 3'd1;
    hold     = 1'b0;
    for (int k = 0; k <= 41; k++) begin
      @(posedge clk); #1;
      chk7("ptr_step", hex1, DIG[(k / 4) % 9]);
    end
    chk7("ptr_hex3", hex3, DIG[1]);
    @(negedge clk) hold = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk7("ptr_hold", hex1, DIG[1]);
    end
    @(negedge clk) face_sel = 3'd3;
    @(posedge clk); #1;
    chk7("ptr_facechg_hex1", hex1, DIG[0]);
    chk7("ptr_facechg_hex3", hex3, DIG[3]);
    repeat (3) @(posedge clk);
    #1 chk7("ptr_facechg_held", hex1, DIG[0]);
    @(negedge clk) hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cnt, first, early;
    early = 0;
    pulse(unsolved_cube());
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      if (solved_valid) early++;
    end
    pulse(solved_cube());
    cnt = 0; first = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 55) chk7("restart_solved_before", {6'd0, solved}, 7'd0);
      if (solved_valid) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk7("restart_early_pulses", 7'(early), 7'd0);
    chk7("restart_pulse_cnt", 7'(cnt), 7'd1);
    chk7("restart_latency", 7'(first), 7'd56);
    chk7("restart_solved", {6'd0, solved}, 7'd1);
  endtask

  task automatic test_invalid_face();
    int cnt, first;
    @(negedge clk) face_sel = 3'd7;
    @(posedge clk); #1;
    chk7("inv_hex0", hex0, DASH);
    chk7("inv_hex1", hex1, DASH);
    chk7("inv_hex2", hex2, DASH);
    chk7("inv_hex3", hex3, DASH);
    chk10("inv_ledr_solved", ledr, 10'h200);
    pulse(unsolved_cube());
    watch(56, cnt, first);
    chk10("inv_ledr_unsolved", ledr, 10'h000);
    chk7("inv_hex0_after", hex0, DASH);
  endtask

  task automatic test_reset_mid_scan();
    int cnt, first;
    @(negedge clk) face_sel = 3'd2;
    pulse(solved_cube());
    watch(56, cnt, first);
    chk7("mid_pre_solved", {6'd0, solved}, 7'd1);
    pulse(unsolved_cube());
    watch(30, cnt, first);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk7("mid_rst_hex0", hex0, BLANK);
    chk7("mid_rst_hex3", hex3, BLANK);
    chk10("mid_rst_ledr", ledr, 10'h000);
    chk7("mid_rst_solved", {6'd0, solved}, 7'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(70, cnt, first);
    chk7("mid_no_pulse", 7'(cnt), 7'd0);
    chk7("mid_solved_after", {6'd0, solved}, 7'd0);
  endtask

  initial begin
    DIG[0] = 7'h40; DIG[1] = 7'h79; DIG[2] = 7'h24; DIG[3] = 7'h30; DIG[4] = 7'h19;
    DIG[5] = 7'h12; DIG[6] = 7'h02; DIG[7] = 7'h78; DIG[8] = 7'h00; DIG[9] = 7'h10;
    test_reset();
    test_solved();
    test_unsolved();
    test_pointer();
    test_back_to_back();
    test_invalid_face();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
